// File: rtl/sr_lock_arbiter.sv
// ---------------------------------------------------------------------------
// sr_lock_arbiter
//   Round-robin arbiter that hands one exclusive lock to one of NREQ
//   requesters at a time. The busy flag has SR semantics: a grant sets it,
//   and a release or a hold timeout clears it. If both a grant and a clear
//   could apply, the clear wins. A hold-timeout watchdog takes the lock back
//   from an owner that keeps it too long. That owner is then masked from
//   arbitration until it drops its request.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   i_req          in   [NREQ-1:0] level requests
//   i_rel          in   [NREQ-1:0] release strobes (only the owner's bit counts)
//   o_gnt          out  [NREQ-1:0] one-hot grant, all-zero when free
//   o_busy         out  lock-owned flag
//   o_owner        out  [OW-1:0] current / last owner index
//   o_timeout_evt  out  one-cycle pulse on a forced release
//   o_penalized    out  [NREQ-1:0] requesters masked after a timeout
// ---------------------------------------------------------------------------
module sr_lock_arbiter #(
  parameter int NREQ    = 4,
  parameter int OW      = 2,
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_rel,
  output logic [NREQ-1:0] o_gnt,
  output logic            o_busy,
  output logic [OW-1:0]   o_owner,
  output logic            o_timeout_evt,
  output logic [NREQ-1:0] o_penalized
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NREQ-1:0] r_gnt,  w_gnt_nxt;
  logic            r_busy, w_busy_nxt;
  logic [OW-1:0]   r_owner, w_owner_nxt;
  logic [OW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [CW-1:0]   r_cnt,  w_cnt_nxt;
  logic            r_tevt, w_tevt_nxt;
  logic [NREQ-1:0] r_pen,  w_pen_nxt;

  logic [NREQ-1:0] w_elig;
  logic [OW:0]     w_pick;
  logic            w_found;
  logic [OW-1:0]   w_win;
  logic [NREQ-1:0] w_win_oh;
  logic            w_rel_hit;
  logic            w_hold_expired;
  logic [OW-1:0]   w_owner_inc;

  // Returns {found, index}. The index is the first set bit of elig, searching
  // upward from ptr and wrapping around.
  function automatic logic [OW:0] pick_winner(input logic [NREQ-1:0] elig,
                                              input logic [OW-1:0]   ptr);
    logic          found;
    logic [OW-1:0] idx;
    logic [OW-1:0] kk;
    int            k;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) begin
        k = k - NREQ;
      end
      kk = OW'(k);
      if (!found && elig[kk]) begin
        found = 1'b1;
        idx   = kk;
      end
    end
    return {found, idx};
  endfunction

  assign w_elig   = i_req & ~r_pen;
  assign w_pick   = pick_winner(w_elig, r_rr_ptr);
  assign w_found  = w_pick[OW];
  assign w_win    = w_pick[OW-1:0];
  assign w_win_oh = NREQ'(1) << w_win;

  // While the lock is owned, r_gnt is one-hot on the owner. Masking i_rel
  // with it therefore keeps only the owner's release bit.
  assign w_rel_hit      = |(i_rel & r_gnt);
  assign w_hold_expired = (r_cnt == CW'(TIMEOUT - 1));
  assign w_owner_inc    = (r_owner == OW'(NREQ - 1)) ? OW'(0) : (r_owner + OW'(1));

  // Next-state and next-output decode for the IDLE/OWNED lock FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_busy_nxt   = r_busy;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    w_cnt_nxt    = r_cnt;
    w_tevt_nxt   = 1'b0;
    // A penalty clears at any edge where the requester is not requesting.
    w_pen_nxt    = r_pen & i_req;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_gnt_nxt   = w_win_oh;
          w_busy_nxt  = 1'b1;
          w_owner_nxt = w_win;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_OWNED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OWNED: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_rel_hit) begin
          // A voluntary release takes priority over a timeout on the same edge.
          w_gnt_nxt    = '0;
          w_busy_nxt   = 1'b0;
          w_rr_ptr_nxt = w_owner_inc;
          w_state_nxt  = ST_IDLE;
        end else if (w_hold_expired) begin
          w_gnt_nxt    = '0;
          w_busy_nxt   = 1'b0;
          w_rr_ptr_nxt = w_owner_inc;
          w_tevt_nxt   = 1'b1;
          w_pen_nxt    = w_pen_nxt | r_gnt;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_state_nxt = ST_OWNED;
        end
      end
      default: begin
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs and arbitration bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt    <= '0;
      r_busy   <= 1'b0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      r_tevt   <= 1'b0;
      r_pen    <= '0;
    end else begin
      r_gnt    <= w_gnt_nxt;
      r_busy   <= w_busy_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tevt   <= w_tevt_nxt;
      r_pen    <= w_pen_nxt;
    end
  end

  assign o_gnt         = r_gnt;
  assign o_busy        = r_busy;
  assign o_owner       = r_owner;
  assign o_timeout_evt = r_tevt;
  assign o_penalized   = r_pen;

endmodule

// File: tb/tb_sr_lock_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sr_lock_arbiter
//   Scoreboard bench for sr_lock_arbiter with the default parameters
//   (NREQ=4, TIMEOUT=16). Before each clock edge, a behavioural model
//   predicts that edge's outputs and pushes them to a queue. After the edge,
//   the prediction is popped and compared with the DUT. Directed scenarios
//   add explicit checks on grant order, hold length and penalty behaviour.
// ---------------------------------------------------------------------------
module tb_sr_lock_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] rel;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic [1:0]      owner;
  logic            timeout_evt;
  logic [NREQ-1:0] penalized;

  sr_lock_arbiter #(.NREQ(NREQ), .OW(2), .TIMEOUT(TIMEOUT), .CW(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req         (req),
    .i_rel         (rel),
    .o_gnt         (gnt),
    .o_busy        (busy),
    .o_owner       (owner),
    .o_timeout_evt (timeout_evt),
    .o_penalized   (penalized)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state. m_hold counts how many cycles the current grant has been high.
  logic [NREQ-1:0] m_gnt;
  logic            m_busy;
  int              m_owner;
  int              m_ptr;
  int              m_hold;
  logic            m_tevt;
  logic [NREQ-1:0] m_pen;

  logic [11:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [11:0] obs_vec();
    return {gnt, busy, owner, timeout_evt, penalized};
  endfunction

  function automatic logic [11:0] model_vec();
    return {m_gnt, m_busy, 2'(m_owner), m_tevt, m_pen};
  endfunction

  task automatic model_reset();
    m_gnt   = '0;
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_hold  = 0;
    m_tevt  = 1'b0;
    m_pen   = '0;
  endtask

  task automatic model_release();
    m_gnt  = '0;
    m_busy = 1'b0;
    m_ptr  = (m_owner + 1) % NREQ;
  endtask

  // Predicts the effect of one clock edge from the inputs as they are now.
  task automatic model_edge();
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] new_pen;
    int              j;
    elig    = req & ~m_pen;
    new_pen = m_pen & req;
    m_tevt  = 1'b0;
    if (!m_busy) begin
      if (elig != '0) begin
        j = m_ptr;
        while (!elig[j]) j = (j + 1) % NREQ;
        m_owner = j;
        m_gnt   = '0;
        m_gnt[j] = 1'b1;
        m_busy  = 1'b1;
        m_hold  = 1;
      end
    end else begin
      if (rel[m_owner]) begin
        model_release();
      end else if (m_hold == TIMEOUT) begin
        model_release();
        m_tevt = 1'b1;
        new_pen[m_owner] = 1'b1;
      end else begin
        m_hold++;
      end
    end
    m_pen = new_pen;
  endtask

  // Runs one clock: predict and push, wait for the edge, then pop and compare.
  task automatic step();
    logic [11:0] e;
    if (!rst_n) model_reset();
    else        model_edge();
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("sb_outputs", 32'(obs_vec()), 32'(e));
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int cnt_hi;
  int cnt_evt;

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    rel   = 4'b0000;
    model_reset();

    // Reset state, with every requester asking for the lock.
    #12;
    check_eq("reset_state", 32'(obs_vec()), 32'(12'h000));
    @(negedge clk);
    rst_n = 1'b1;

    // The first edge after reset grants requester 0.
    step();
    check_eq("t1_first_gnt", 32'(gnt), 32'(4'b0001));
    check_eq("t1_busy", 32'(busy), 32'(1'b1));

    // Round-robin: each owner releases at the third edge after its grant.
    for (int g = 0; g < 5; g++) begin
      check_eq("t2_rr_owner", 32'(owner), 32'(exp_order[g]));
      step();
      step();
      rel = 4'(1) << owner;
      step();
      rel = 4'b0000;
      check_eq("t2_gap_low", 32'(gnt), 32'(4'b0000));
      if (g < 4) step();
    end

    // Timeout: requester 2 holds the lock without ever releasing it.
    req     = 4'b0100;
    cnt_hi  = 0;
    cnt_evt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (gnt == 4'b0100) cnt_hi++;
      if (timeout_evt) cnt_evt++;
    end
    check_eq("t3_hold_cycles", 32'(cnt_hi), 32'(TIMEOUT));
    check_eq("t3_evt_pulses", 32'(cnt_evt), 32'(1));
    check_eq("t3_penalized", 32'(penalized), 32'(4'b0100));
    req = 4'b0000;
    step();
    check_eq("t3_pen_clear", 32'(penalized), 32'(4'b0000));
    req = 4'b0100;
    step();
    check_eq("t3_regrant", 32'(gnt), 32'(4'b0100));
    rel = 4'b0100;
    step();
    rel = 4'b0000;

    // The owner releases on the same edge as the timeout: normal release.
    req = 4'b0010;
    step();
    check_eq("t4_gnt1", 32'(gnt), 32'(4'b0010));
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    rel = 4'b0010;
    step();
    rel = 4'b0000;
    check_eq("t4_gnt", 32'(gnt), 32'(4'b0000));
    check_eq("t4_evt", 32'(timeout_evt), 32'(1'b0));
    check_eq("t4_pen", 32'(penalized), 32'(4'b0000));
    req = 4'b0000;
    step();

    // Non-owner releases are ignored; the owner dropping req keeps the lock.
    req = 4'b1000;
    step();
    check_eq("t5_gnt3", 32'(gnt), 32'(4'b1000));
    req = 4'b1011;
    rel = 4'b0011;
    step();
    check_eq("t5_nonowner_rel", 32'(gnt), 32'(4'b1000));
    rel = 4'b0000;
    req = 4'b0000;
    step();
    step();
    check_eq("t5_req_drop_hold", 32'(gnt), 32'(4'b1000));
    rel = 4'b1000;
    step();
    rel = 4'b0000;
    check_eq("t5_released", 32'(busy), 32'(1'b0));

    // Move the round-robin pointer to 3, then reset in the middle of a grant.
    req = 4'b0100;
    step();
    rel = 4'b0100;
    step();
    rel = 4'b0000;
    step();
    check_eq("t6_gnt2", 32'(gnt), 32'(4'b0100));
    for (int i = 0; i < 5; i++) step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("t6_async_gnt", 32'(gnt), 32'(4'b0000));
    check_eq("t6_async_busy", 32'(busy), 32'(1'b0));
    req = 4'b1111;
    step();
    rst_n = 1'b1;
    step();
    check_eq("t6_restart_owner0", 32'(gnt), 32'(4'b0001));

    // Random traffic, checked against the model every cycle.
    for (int i = 0; i < 400; i++) begin
      req = 4'($urandom_range(0, 15));
      rel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
